id_ex_stage: RTL and testbench

Decode-to-execute stage of the my_riscv pipeline. It registers one decoded RV32I instruction and derives the 4-bit ALU operation code. Each cycle it drives `alu_ctrl`, `alu_in1` and `alu_in2` to the `alu` block, applying EX/MEM and MEM/WB forwarding to the operands. It also detects load-use hazards, inserts bubbles, and honours pipeline stall and flush.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/alu_ctrl_decode.sv | 84 ++++++++
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared my_riscv definitions: datapath width, ALU operation codes, base opcodes
// and the operand forwarding selector used by the execute stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            exm_we,
    input logic [4:0]      exm_rd,
    input logic [XLEN-1:0] exm_data,
    input logic            mwb_we,
    input logic [4:0]      mwb_rd,
    input logic [XLEN-1:0] mwb_data
  );
    if (exm_we && (exm_rd == rs) && (rs != 5'd0))      return exm_data;
    else if (mwb_we && (mwb_rd == rs) && (rs != 5'd0)) return mwb_data;
    else                                               return rf_data;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into the ALU code, operand
// selects, pipeline control bits and register-use flags for hazard detection.
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       op1_pc_o,
  output logic       op1_zero_o,
  output logic       op2_rs2_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o  = ALU_ADD;
    op1_pc_o    = 1'b0;
    op1_zero_o  = 1'b0;
    op2_rs2_o   = 1'b0;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    uses_rs1_o  = 1'b1;
    uses_rs2_o  = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        reg_write_o = 1'b1;
        op2_rs2_o   = (opcode_i == OPC_OP);
        uses_rs2_o  = (opcode_i == OPC_OP);
        case (funct3_i)
          3'b000:  alu_ctrl_o = ((opcode_i == OPC_OP) && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        branch_o   = 1'b1;
        op2_rs2_o  = 1'b1;
        uses_rs2_o = 1'b1;
        case (funct3_i[2:1])
          2'b00:   alu_ctrl_o = ALU_SUB;
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        mem_read_o  = 1'b1;
        reg_write_o = 1'b1;
      end
      OPC_STORE: begin
        mem_write_o = 1'b1;
        uses_rs2_o  = 1'b1;
      end
      OPC_LUI: begin
        op1_zero_o  = 1'b1;
        reg_write_o = 1'b1;
        uses_rs1_o  = 1'b0;
      end
      OPC_AUIPC, OPC_JAL: begin
        op1_pc_o    = 1'b1;
        reg_write_o = 1'b1;
        uses_rs1_o  = 1'b0;
      end
      OPC_JALR:  reg_write_o = 1'b1;
      default:   illegal_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures one decoded instruction, forwards operands
// into the ALU and raises a combinational load-use stall request.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            exm_we_i,
  input  logic [4:0]      exm_rd_i,
  input  logic [XLEN-1:0] exm_data_i,
  input  logic            mwb_we_i,
  input  logic [4:0]      mwb_rd_i,
  input  logic [XLEN-1:0] mwb_data_i,
  output logic            valid_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] alu_in1_o,
  output logic [XLEN-1:0] alu_in2_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic [2:0]      funct3_o,
  output logic            hazard_o,
  output logic            illegal_o
);

  logic [3:0] dec_alu_ctrl;
  logic dec_op1_pc, dec_op1_zero, dec_op2_rs2, dec_reg_write, dec_mem_read;
  logic dec_mem_write, dec_branch, dec_uses_rs1, dec_uses_rs2, dec_illegal;

  alu_ctrl_decode u_decode (
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7b5_i  (funct7b5_i),
    .alu_ctrl_o  (dec_alu_ctrl),
    .op1_pc_o    (dec_op1_pc),
    .op1_zero_o  (dec_op1_zero),
    .op2_rs2_o   (dec_op2_rs2),
    .reg_write_o (dec_reg_write),
    .mem_read_o  (dec_mem_read),
    .mem_write_o (dec_mem_write),
    .branch_o    (dec_branch),
    .uses_rs1_o  (dec_uses_rs1),
    .uses_rs2_o  (dec_uses_rs2),
    .illegal_o   (dec_illegal)
  );

  logic            valid_q, valid_d, op1_pc_q, op1_pc_d, op1_zero_q, op1_zero_d;
  logic            op2_rs2_q, op2_rs2_d, reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d, branch_q, branch_d, illegal_q, illegal_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
  logic            cap;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign hazard_o = valid_q & mem_read_q & (rd_q != 5'd0) & valid_i &
                    ((dec_uses_rs1 & (rs1_i == rd_q)) | (dec_uses_rs2 & (rs2_i == rd_q)));
  assign cap = valid_i & ~dec_illegal;

  // valid_o qualifies every EX output; stall_i holds the slot (valid stays as is),
  // flush_i or a load-use bubble empties it, otherwise the decode slot moves in.
  always_comb begin
    valid_d     = valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    op1_pc_d    = op1_pc_q;
    op1_zero_d  = op1_zero_q;
    op2_rs2_d   = op2_rs2_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    illegal_d   = 1'b0;
    if (flush_i || (!stall_i && hazard_o)) begin
      valid_d     = 1'b0;
      alu_ctrl_d  = ALU_ADD;
      op1_pc_d    = 1'b0;
      op1_zero_d  = 1'b0;
      op2_rs2_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
    end else if (!stall_i) begin
      valid_d     = cap;
      alu_ctrl_d  = cap ? dec_alu_ctrl : ALU_ADD;
      op1_pc_d    = cap & dec_op1_pc;
      op1_zero_d  = cap & dec_op1_zero;
      op2_rs2_d   = cap & dec_op2_rs2;
      reg_write_d = cap & dec_reg_write & (rd_i != 5'd0);
      mem_read_d  = cap & dec_mem_read;
      mem_write_d = cap & dec_mem_write;
      branch_d    = cap & dec_branch;
      funct3_d    = funct3_i;
      rd_d        = rd_i;
      rs1_d       = rs1_i;
      rs2_d       = rs2_i;
      rs1_data_d  = rs1_data_i;
      rs2_data_d  = rs2_data_i;
      imm_d       = imm_i;
      pc_d        = pc_i;
      illegal_d   = valid_i & dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;  alu_ctrl_q <= ALU_ADD; op1_pc_q <= 1'b0;  op1_zero_q <= 1'b0;
      op2_rs2_q <= 1'b0; reg_write_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0;
      branch_q <= 1'b0; funct3_q <= 3'd0;    rd_q <= 5'd0;       rs1_q <= 5'd0;
      rs2_q <= 5'd0;    rs1_data_q <= '0;    rs2_data_q <= '0;   imm_q <= '0;
      pc_q <= '0;       illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;  alu_ctrl_q <= alu_ctrl_d; op1_pc_q <= op1_pc_d;
      op1_zero_q <= op1_zero_d; op2_rs2_q <= op2_rs2_d; reg_write_q <= reg_write_d;
      mem_read_q <= mem_read_d; mem_write_q <= mem_write_d; branch_q <= branch_d;
      funct3_q <= funct3_d; rd_q <= rd_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
      rs1_data_q <= rs1_data_d; rs2_data_q <= rs2_data_d; imm_q <= imm_d;
      pc_q <= pc_d; illegal_q <= illegal_d;
    end
  end

  assign rs1_fwd = fwd_sel(rs1_q, rs1_data_q, exm_we_i, exm_rd_i, exm_data_i,
                           mwb_we_i, mwb_rd_i, mwb_data_i);
  assign rs2_fwd = fwd_sel(rs2_q, rs2_data_q, exm_we_i, exm_rd_i, exm_data_i,
                           mwb_we_i, mwb_rd_i, mwb_data_i);

  assign valid_o      = valid_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign alu_in1_o    = op1_pc_q ? pc_q : (op1_zero_q ? '0 : rs1_fwd);
  assign alu_in2_o    = op2_rs2_q ? rs2_fwd : imm_q;
  assign store_data_o = rs2_fwd;
  assign rd_o         = rd_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign branch_o     = branch_q;
  assign funct3_o     = funct3_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/flush/hazard
// sequences and a randomized run against an instruction-level reference model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid_i, funct7b5_i, stall_i, flush_i, exm_we_i, mwb_we_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rs1_i, rs2_i, rd_i, exm_rd_i, mwb_rd_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i, exm_data_i, mwb_data_i;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, branch_o, hazard_o, illegal_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_in1_o, alu_in2_o, store_data_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .exm_we_i(exm_we_i), .exm_rd_i(exm_rd_i),
    .exm_data_i(exm_data_i), .mwb_we_i(mwb_we_i), .mwb_rd_i(mwb_rd_i),
    .mwb_data_i(mwb_data_i), .valid_o(valid_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_in1_o(alu_in1_o), .alu_in2_o(alu_in2_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .funct3_o(funct3_o),
    .hazard_o(hazard_o), .illegal_o(illegal_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instruction held in EX ----------------
  typedef struct {
    logic        v;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } slot_t;
  slot_t m_ex;
  logic  m_ill;

  typedef struct packed {
    logic        valid, hazard, illegal, rw, mr, mw, br;
    logic [3:0]  alu;
    logic [31:0] in1, in2, st;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic is_legal(input logic [6:0] o);
    return o inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE,
                     OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    logic [3:0] arith [8];
    arith = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd2, 4'd6, 4'd3, 4'd4};
    if (o == OPC_OP || o == OPC_OP_IMM) begin
      if (f3 == 3'd0 && o == OPC_OP && f7) return 4'd1;
      if (f3 == 3'd5 && f7) return 4'd7;
      return arith[f3];
    end
    if (o == OPC_BRANCH) begin
      if (f3 inside {3'd0, 3'd1}) return 4'd1;
      if (f3 inside {3'd4, 3'd5}) return 4'd9;
      if (f3 inside {3'd6, 3'd7}) return 4'd8;
    end
    return 4'd0;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (exm_we_i && exm_rd_i == rs) return exm_data_i;
    if (mwb_we_i && mwb_rd_i == rs) return mwb_data_i;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    logic u1, u2;
    u1 = !(opcode_i inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    u2 = opcode_i inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    return m_ex.v && m_ex.opc == OPC_LOAD && m_ex.rd != 0 && valid_i &&
           ((u1 && rs1_i == m_ex.rd) || (u2 && rs2_i == m_ex.rd));
  endfunction

  task automatic compare_model();
    exp_t e, g;
    e = '0;
    e.valid = m_ex.v; e.hazard = ref_hazard(); e.illegal = m_ill;
    if (m_ex.v) begin
      e.rw  = (m_ex.opc inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                                OPC_JAL, OPC_JALR}) && m_ex.rd != 0;
      e.mr  = m_ex.opc == OPC_LOAD;
      e.mw  = m_ex.opc == OPC_STORE;
      e.br  = m_ex.opc == OPC_BRANCH;
      e.alu = ref_alu(m_ex.opc, m_ex.f3, m_ex.f7);
      e.in1 = (m_ex.opc inside {OPC_AUIPC, OPC_JAL}) ? m_ex.pc :
              (m_ex.opc == OPC_LUI) ? 32'd0 : ref_fwd(m_ex.rs1, m_ex.d1);
      e.in2 = (m_ex.opc inside {OPC_OP, OPC_BRANCH}) ? ref_fwd(m_ex.rs2, m_ex.d2) : m_ex.imm;
      e.st  = ref_fwd(m_ex.rs2, m_ex.d2);
      e.rd  = m_ex.rd;
      e.f3  = m_ex.f3;
    end
    exp_q.push_back(e);
    g = exp_q.pop_front();
    chk("m_valid", {31'd0, valid_o}, {31'd0, g.valid});
    chk("m_hazard", {31'd0, hazard_o}, {31'd0, g.hazard});
    chk("m_illegal", {31'd0, illegal_o}, {31'd0, g.illegal});
    chk("m_ctrl", {28'd0, reg_write_o, mem_read_o, mem_write_o, branch_o},
        {28'd0, g.rw, g.mr, g.mw, g.br});
    if (g.valid) begin
      chk("m_alu_ctrl", {28'd0, alu_ctrl_o}, {28'd0, g.alu});
      chk("m_alu_in1", alu_in1_o, g.in1);
      chk("m_alu_in2", alu_in2_o, g.in2);
      chk("m_store_data", store_data_o, g.st);
      chk("m_rd_f3", {24'd0, rd_o, funct3_o}, {24'd0, g.rd, g.f3});
    end
  endtask

  task automatic model_reset();
    m_ex = '{v: 1'b0, opc: 7'd0, f3: 3'd0, f7: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
             d1: 32'd0, d2: 32'd0, imm: 32'd0, pc: 32'd0};
    m_ill = 1'b0;
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, return just after it.
  task automatic tick();
    logic h;
    @(negedge clk);
    compare_model();
    h = ref_hazard();
    @(posedge clk);
    if (rst) model_reset();
    else if (flush_i || (!stall_i && h)) begin m_ex.v = 1'b0; m_ill = 1'b0; end
    else if (stall_i) m_ill = 1'b0;
    else begin
      m_ill = valid_i && !is_legal(opcode_i);
      if (valid_i && is_legal(opcode_i))
        m_ex = '{v: 1'b1, opc: opcode_i, f3: funct3_i, f7: funct7b5_i, rs1: rs1_i,
                 rs2: rs2_i, rd: rd_i, d1: rs1_data_i, d2: rs2_data_i, imm: imm_i, pc: pc_i};
      else m_ex.v = 1'b0;
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             input logic [31:0] da, input logic [31:0] db,
                             input logic [31:0] imm, input logic [31:0] pc);
    valid_i = 1'b1; opcode_i = o; funct3_i = f3; funct7b5_i = f7;
    rs1_i = a; rs2_i = b; rd_i = d; rs1_data_i = da; rs2_data_i = db; imm_i = imm; pc_i = pc;
  endtask

  task automatic drive_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mr, input logic [31:0] md);
    exm_we_i = ew; exm_rd_i = er; exm_data_i = ed;
    mwb_we_i = mw; mwb_rd_i = mr; mwb_data_i = md;
  endtask

  task automatic drive_idle();
    drive_instr(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    valid_i = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        ew; logic [4:0] er; logic [31:0] ed;
    logic        mw; logic [4:0] mr; logic [31:0] md;
    logic [3:0]  e_alu;
    logic [31:0] e_in1, e_in2;
    logic        e_rw;
  } vec_t;
  vec_t vecs [10];

  initial begin
    vecs[0] = '{"add_exm", OPC_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 32'd0,
                1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 32'd0, 4'd0, 32'd100, 32'd7, 1'b1};
    vecs[1] = '{"srai", OPC_OP_IMM, 3'd5, 1'b1, 5'd3, 5'd0, 5'd6, 32'hFFFF_FFF0, 32'd0, 32'd4,
                32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd7, 32'hFFFF_FFF0, 32'd4, 1'b1};
    vecs[2] = '{"bltu_mwb", OPC_BRANCH, 3'd6, 1'b0, 5'd1, 5'd6, 5'd0, 32'd3, 32'd9, 32'd16,
                32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'd55, 4'd8, 32'd3, 32'd55, 1'b0};
    vecs[3] = '{"auipc", OPC_AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h2000,
                32'h1000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd0, 32'h1000, 32'h2000, 1'b1};
    vecs[4] = '{"fwd_prio", OPC_OP, 3'd0, 1'b0, 5'd3, 5'd4, 5'd8, 32'd1, 32'd2, 32'd0, 32'd0,
                1'b1, 5'd3, 32'd11, 1'b1, 5'd3, 32'd22, 4'd0, 32'd11, 32'd2, 1'b1};
    vecs[5] = '{"x0_nofwd", OPC_OP, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 32'd5, 32'd6, 32'd0, 32'd0,
                1'b1, 5'd0, 32'd99, 1'b1, 5'd0, 32'd98, 4'd0, 32'd5, 32'd6, 1'b1};
    vecs[6] = '{"sub", OPC_OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd10, 32'd20, 32'd3, 32'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd1, 32'd20, 32'd3, 1'b1};
    vecs[7] = '{"addi_f7", OPC_OP_IMM, 3'd0, 1'b1, 5'd1, 5'd0, 5'd11, 32'd20, 32'd0, 32'd5,
                32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd0, 32'd20, 32'd5, 1'b1};
    vecs[8] = '{"lui_rd0", OPC_LUI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd123, 32'd0,
                32'h1234_5000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0,
                32'h1234_5000, 1'b0};
    vecs[9] = '{"sra_mwb", OPC_OP, 3'd5, 1'b1, 5'd2, 5'd3, 5'd12, 32'h8000_0000, 32'd1, 32'd0,
                32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hF0, 4'd7, 32'hF0, 32'd1, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] opcs [10];
    opcs = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH,
             OPC_JAL, OPC_JALR, 7'h7F};
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_idle();
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // reset state
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
    chk("rst_alu_in1", alu_in1_o, 32'd0);
    chk("rst_alu_in2", alu_in2_o, 32'd0);
    chk("rst_store", store_data_o, 32'd0);
    chk("rst_ctrl", {24'd0, rd_o, reg_write_o, mem_read_o, mem_write_o, branch_o, funct3_o,
                     illegal_o, hazard_o}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive_instr(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].pc);
      drive_fwd(vecs[i].ew, vecs[i].er, vecs[i].ed, vecs[i].mw, vecs[i].mr, vecs[i].md);
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, valid_o}, 32'd1);
      chk({vecs[i].name, "_alu_ctrl"}, {28'd0, alu_ctrl_o}, {28'd0, vecs[i].e_alu});
      chk({vecs[i].name, "_in1"}, alu_in1_o, vecs[i].e_in1);
      chk({vecs[i].name, "_in2"}, alu_in2_o, vecs[i].e_in2);
      chk({vecs[i].name, "_rw"}, {31'd0, reg_write_o}, {31'd0, vecs[i].e_rw});
    end
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // load-use: LOAD x4 in EX, dependent OP in decode
    drive_instr(OPC_LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'd8, 32'd0);
    tick();
    drive_instr(OPC_OP, 3'd0, 1'b0, 5'd1, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 32'd0);
    #1 chk("lu_hazard", {31'd0, hazard_o}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, valid_o}, 32'd0);
    chk("lu_hazard_drop", {31'd0, hazard_o}, 32'd0);
    tick();
    chk("lu_capture_valid", {31'd0, valid_o}, 32'd1);

    // load with rd=x0 never stalls
    drive_instr(OPC_LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd8, 32'd0);
    tick();
    drive_instr(OPC_OP, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'd1, 32'd2, 32'd0, 32'd0);
    #1 chk("lu_rd0_hazard", {31'd0, hazard_o}, 32'd0);
    tick();

    // hazard persists while stall holds the load
    drive_instr(OPC_LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'd8, 32'd0);
    tick();
    drive_instr(OPC_STORE, 3'd2, 1'b0, 5'd2, 5'd4, 5'd0, 32'd0, 32'd0, 32'd4, 32'd0);
    stall_i = 1'b1;
    tick();
    chk("stall_hazard_hold", {31'd0, hazard_o}, 32'd1);
    chk("stall_load_held", {30'd0, valid_o, mem_read_o}, 32'd3);
    stall_i = 1'b0;
    tick();
    chk("stall_bubble", {30'd0, valid_o, hazard_o}, 32'd0);
    tick();

    // flush beats stall and hazard together
    drive_instr(OPC_LOAD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'd8, 32'd0);
    tick();
    drive_instr(OPC_OP, 3'd0, 1'b0, 5'd4, 5'd0, 5'd5, 32'd1, 32'd2, 32'd0, 32'd0);
    stall_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_hazard_seen", {31'd0, hazard_o}, 32'd1);
    tick();
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // stall three cycles: outputs hold while operands still re-forward
    drive_instr(OPC_OP, 3'd4, 1'b0, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'd0, 32'd0);
    tick();
    stall_i = 1'b1;
    drive_instr(OPC_OP_IMM, 3'd6, 1'b0, 5'd3, 5'd0, 5'd10, 32'd40, 32'd0, 32'd1, 32'd0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) drive_fwd(1'b1, 5'd1, 32'd77, 1'b0, 5'd0, 32'd0);
      tick();
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
      chk("stall_alu_ctrl", {28'd0, alu_ctrl_o}, 32'd2);
      chk("stall_in1", alu_in1_o, (c == 2) ? 32'd77 : 32'd5);
      chk("stall_rd", {27'd0, rd_o}, 32'd9);
    end
    stall_i = 1'b0;
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // illegal opcode: one-cycle pulse, captured as bubble; suppressed under stall
    drive_instr(7'h7F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("illegal_pulse", {30'd0, illegal_o, valid_o}, 32'd2);
    drive_idle();
    tick();
    chk("illegal_drop", {31'd0, illegal_o}, 32'd0);
    drive_instr(7'h7F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0);
    stall_i = 1'b1;
    tick();
    chk("illegal_stalled", {31'd0, illegal_o}, 32'd0);
    stall_i = 1'b0;

    // reset mid-stream during a valid STORE
    drive_instr(OPC_STORE, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd10, 32'd20, 32'd4, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'd0, valid_o}, 32'd0);
    chk("mrst_mem_write", {31'd0, mem_write_o}, 32'd0);
    chk("mrst_in1_in2", alu_in1_o | alu_in2_o | store_data_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_resume", {30'd0, valid_o, mem_write_o}, 32'd3);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      drive_instr(($urandom_range(0, 19) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 9)],
                  3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, $urandom);
      valid_i = ($urandom_range(0, 7) != 0);
      drive_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 11) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
